// File: rtl/light_seq_ctrl.sv
// light_seq_ctrl: button-stepped mode selector, programmable step tick and 7-LED pattern decode.
// Define LSC_BOUNCE_EN for a ping-pong CHASE pattern instead of 6->0 wrap.
module light_seq_ctrl #(
    parameter int BASE_DIV = 4,
    parameter int DIV_W    = 19
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic [1:0] rate_sel,
    output logic [1:0] mode,
    output logic [2:0] step,
    output logic       step_tick,
    output logic [6:0] led
);
    typedef enum logic [1:0] {OFF = 2'd0, STEADY = 2'd1, BLINK = 2'd2, CHASE = 2'd3} mode_t;
    mode_t            mode_q, mode_d;
    logic             btn_q, press;
    logic [DIV_W-1:0] count_q, count_d, limit;
    logic [2:0]       step_q, step_d, step_up;
    logic             phase_q, phase_d;
`ifdef LSC_BOUNCE_EN
    logic             dir_q, dir_d;
    logic [2:0]       step_dn;
    assign step_dn = (step_q == 3'd0 || step_q == 3'd7) ? 3'd0 : step_q - 3'd1;
`endif
    assign press     = btn & ~btn_q;
    assign limit     = (DIV_W'(BASE_DIV) << rate_sel) - DIV_W'(1);
    // >= rather than == so shrinking rate_sel mid-period ticks at once instead of wrapping
    assign step_tick = (mode_q != OFF) && (count_q >= limit);
    assign step_up   = (step_q >= 3'd6) ? 3'd0 : step_q + 3'd1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= OFF;
            btn_q   <= 1'b0;
            count_q <= '0;
            step_q  <= '0;
            phase_q <= 1'b0;
`ifdef LSC_BOUNCE_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            mode_q  <= mode_d;
            btn_q   <= btn;
            count_q <= count_d;
            step_q  <= step_d;
            phase_q <= phase_d;
`ifdef LSC_BOUNCE_EN
            dir_q   <= dir_d;
`endif
        end
    end
    always_comb begin
        mode_d  = mode_q;
        count_d = count_q;
        step_d  = step_q;
        phase_d = phase_q;
`ifdef LSC_BOUNCE_EN
        dir_d   = dir_q;
`endif
        if (press) begin
            mode_d  = mode_t'(mode_q + 2'd1);
            count_d = '0;
            step_d  = '0;
            phase_d = 1'b0;
`ifdef LSC_BOUNCE_EN
            dir_d   = 1'b0;
`endif
        end else if (mode_q == OFF) begin
            count_d = '0;
            step_d  = '0;
            phase_d = 1'b0;
        end else begin
            count_d = step_tick ? '0 : count_q + DIV_W'(1);
            phase_d = (mode_q == BLINK) && (phase_q ^ step_tick);
            if (step_tick) begin
`ifdef LSC_BOUNCE_EN
                if (mode_q == CHASE && dir_q) begin
                    step_d = step_dn;
                    dir_d  = (step_dn != 3'd0);
                end else begin
                    step_d = step_up;
                    dir_d  = (mode_q == CHASE) && (step_up == 3'd6);
                end
`else
                step_d = step_up;
`endif
            end
        end
    end
    always_comb begin
        led = (mode_q == STEADY) ? 7'h7F :
              (mode_q == BLINK)  ? (phase_q ? 7'h00 : 7'h7F) :
              (mode_q == CHASE)  ? (7'b1 << step_q) : 7'h00;
    end
    assign mode = mode_q;
    assign step = step_q;
endmodule
